fpu_issue_queue: RTL and testbench
==================================

# fpu_issue_queue

Command buffer and result register wrapped around the combinational single-precision FPU. Accepts operand/opcode commands over a valid/ready handshake and queues them in a DEPTH-entry FIFO. It presents the FIFO head to the FPU inputs, then registers the FPU result with its opcode tag onto a valid/ready result port. This makes the combinational FPU a streaming, back-pressurable, one-result-per-cycle pipeline stage.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- i_w_clk  in  1  clock, rising edge
- i_w_rst_n  in  1  asynchronous active-low reset
- i_w_cmd_valid  in  1  command present
- o_w_cmd_ready  out  1  command accepted when valid & ready at rising edge
- i_w_cmd_op1  in  32  operand 1 (IEEE 754 single)
- i_w_cmd_op2  in  32  operand 2
- i_w_cmd_opsel  in  3  FPU opcode (000 add … 111 eq)
- o_w_fpu_op1  out  32  to FPU i_w_op1
- o_w_fpu_op2  out  32  to FPU i_w_op2
- o_w_fpu_opsel  out  3  to FPU i_w_opsel
- i_w_fpu_out  in  32  from FPU o_w_out (combinational)
- o_w_res_valid  out  1  result present
- i_w_res_ready  in  1  result consumed when valid & ready at rising edge
- o_w_res_data  out  32  registered FPU result
- o_w_res_opsel  out  3  opcode that produced o_w_res_data
- o_w_count  out  $clog2(DEPTH)+1  FIFO occupancy, excluding result register

## Operation
- Storage: DEPTH × 67-bit entries {op1, op2, opsel}; write pointer, read pointer and count are registered.
- Pointers wrap modulo DEPTH.
- push = i_w_cmd_valid & o_w_cmd_ready.
- o_w_cmd_ready = i_w_rst_n & (count != DEPTH). It has no combinational dependence on i_w_res_ready, so a pop in the same cycle does not free a slot for a push at full.
- FPU drive: head entry when count != 0. All-zero (op1 = 0, op2 = 0, opsel = 000) when empty.
- slot_free = !o_w_res_valid | i_w_res_ready.
- pop = (count != 0) & slot_free. On pop:
  - o_w_res_data ← i_w_fpu_out
  - o_w_res_opsel ← head opsel
  - o_w_res_valid ← 1
  - read pointer advances
- When there is no pop and the result handshake completes, o_w_res_valid ← 0. o_w_res_data and o_w_res_opsel hold their last values.
- When o_w_res_valid & !i_w_res_ready, the result register and its tag are held stable.
- Count update: push only → +1; pop only → −1; both → unchanged.
- Commands are completed strictly in acceptance order. No reordering or dropping.
- i_w_cmd_* are sampled only on push. A valid command with ready low is ignored, and the sender must hold it.

## Timing
- Reset (asynchronous assert, release synchronous to i_w_clk):
  - pointers = 0, count = 0
  - o_w_res_valid = 0, o_w_res_data = 0, o_w_res_opsel = 0
  - o_w_cmd_ready = 0 while i_w_rst_n is low, 1 from the first cycle after release
  - FPU drive = all-zero
- Reset mid-operation discards all queued commands and any held result. There is no partial output.
- Latency: command pushed at edge k appears on the FPU inputs after edge k. If the result slot is free, it is captured at edge k+1, so o_w_res_valid is high after edge k+1 (2 cycles).
- Throughput: 1 command/cycle and 1 result/cycle while i_w_res_ready is held high.
- Maximum in flight: DEPTH + 1 (FIFO plus result register).
- Full: count = DEPTH → o_w_cmd_ready low in the same cycle.
- Empty: count = 0 → no pop, and o_w_res_valid falls after the result handshake.

## Test plan
- Single add: op1 = 0x3F800000, op2 = 0x40000000, opsel = 000, res_ready = 1 → o_w_res_valid high for exactly 1 cycle, two edges after the push, with data 0x40400000 and opsel 000.
- Streaming: res_ready = 1, 8 back-to-back commands → 8 consecutive valid results in order:
  - mul 0x40000000 × 0x40400000 → 0x40C00000
  - neg 0x3F800000 → 0xBF800000
  - gt 0x40000000 vs 0x3F800000 → 0x3F800000
  - eq with unequal operands → 0x00000000
  - plus 4 further commands, results in acceptance order
- Backpressure: res_ready = 0, push until refused → 5 accepted (DEPTH = 4), o_w_count = 4, cmd_ready low, and the first result held stable. Then raise res_ready → the remaining 4 results drain on consecutive cycles, count reaches 0, and cmd_ready is high after the first drain edge.
- Full boundary: count = 4, cmd_valid = 1, res_ready = 1 → no push that cycle, count becomes 3, and the command is accepted on the next edge.
- Simultaneous push/pop: count = 2, push and pop on the same edge → count remains 2 and order is preserved.
- Reset mid-stream: 3 commands queued with a result pending, then assert i_w_rst_n low for 1 cycle → o_w_res_valid = 0, count = 0, FPU drive zero, and no stale results after release.

Source files
------------

// File: rtl/fpu_issue_queue.sv
// Command FIFO and registered result slot around a combinational FPU.
// The FIFO head drives the FPU. Each pop captures the FPU output together with its opcode tag.
module fpu_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       i_w_clk,
  input  logic                       i_w_rst_n,
  input  logic                       i_w_cmd_valid,
  output logic                       o_w_cmd_ready,
  input  logic [31:0]                i_w_cmd_op1,
  input  logic [31:0]                i_w_cmd_op2,
  input  logic [2:0]                 i_w_cmd_opsel,
  output logic [31:0]                o_w_fpu_op1,
  output logic [31:0]                o_w_fpu_op2,
  output logic [2:0]                 o_w_fpu_opsel,
  input  logic [31:0]                i_w_fpu_out,
  output logic                       o_w_res_valid,
  input  logic                       i_w_res_ready,
  output logic [31:0]                o_w_res_data,
  output logic [2:0]                 o_w_res_opsel,
  output logic [$clog2(DEPTH):0]     o_w_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [66:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          res_valid_r;
  logic [31:0]   res_data_r;
  logic [2:0]    res_opsel_r;

  logic          not_empty_s;
  logic          slot_free_s;
  logic          push_s;
  logic          pop_s;
  logic [66:0]   head_s;

  // Ready depends only on registered occupancy, so a pop at full never frees a slot in that cycle.
  assign not_empty_s   = (count_r != {CW{1'b0}});
  assign o_w_cmd_ready = i_w_rst_n & (count_r != FULL_C);
  assign slot_free_s   = ~res_valid_r | i_w_res_ready;
  assign push_s        = i_w_cmd_valid & o_w_cmd_ready;
  assign pop_s         = not_empty_s & slot_free_s;
  assign head_s        = mem_r[rd_ptr_r];

  // Present the head entry to the FPU, or all zeros when the queue is empty.
  always_comb begin
    o_w_fpu_op1   = 32'd0;
    o_w_fpu_op2   = 32'd0;
    o_w_fpu_opsel = 3'd0;
    if (not_empty_s) begin
      o_w_fpu_op1   = head_s[66:35];
      o_w_fpu_op2   = head_s[34:3];
      o_w_fpu_opsel = head_s[2:0];
    end else begin
      o_w_fpu_op1   = 32'd0;
      o_w_fpu_op2   = 32'd0;
      o_w_fpu_opsel = 3'd0;
    end
  end

  // Command storage. Stale contents are never visible because the FPU drive is gated by occupancy.
  always_ff @(posedge i_w_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {i_w_cmd_op1, i_w_cmd_op2, i_w_cmd_opsel};
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Result slot. Data and tag hold after the handshake and change only on a pop.
  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      res_valid_r <= 1'b0;
      res_data_r  <= 32'd0;
      res_opsel_r <= 3'd0;
    end else if (pop_s) begin
      res_valid_r <= 1'b1;
      res_data_r  <= i_w_fpu_out;
      res_opsel_r <= head_s[2:0];
    end else if (i_w_res_ready) begin
      res_valid_r <= 1'b0;
    end
  end

  assign o_w_res_valid = res_valid_r;
  assign o_w_res_data  = res_data_r;
  assign o_w_res_opsel = res_opsel_r;
  assign o_w_count     = count_r;

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Directed self-checking bench for fpu_issue_queue. A table-driven stand-in replaces the FPU.
module tb_fpu_issue_queue;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_op1;
  logic [31:0] cmd_op2;
  logic [2:0]  cmd_opsel;
  logic [31:0] fpu_op1;
  logic [31:0] fpu_op2;
  logic [2:0]  fpu_opsel;
  logic [31:0] fpu_out;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [2:0]  res_opsel;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  // Vectors 0..7 are the streaming set and vector 8 is the single add. Results are hand-computed IEEE values.
  localparam int NV = 9;
  localparam logic [31:0] V_OP1 [NV] = '{32'h40000000, 32'h3F800000, 32'h40000000, 32'h40000000,
                                         32'h40A00000, 32'h3F000000, 32'h3F800000, 32'h40000000,
                                         32'h3F800000};
  localparam logic [31:0] V_OP2 [NV] = '{32'h40400000, 32'h00000000, 32'h3F800000, 32'h3F800000,
                                         32'h40400000, 32'h3F000000, 32'hBF800000, 32'h40000000,
                                         32'h40000000};
  localparam logic [2:0]  V_SEL [NV] = '{3'b010, 3'b100, 3'b110, 3'b111,
                                         3'b001, 3'b000, 3'b010, 3'b111,
                                         3'b000};
  localparam logic [31:0] V_RES [NV] = '{32'h40C00000, 32'hBF800000, 32'h3F800000, 32'h00000000,
                                         32'h40000000, 32'h3F800000, 32'hBF800000, 32'h3F800000,
                                         32'h40400000};

  function automatic logic [31:0] fpu_stub(logic [31:0] a, logic [31:0] b, logic [2:0] op);
    fpu_stub = 32'hDEADBEEF;
    for (int i = 0; i < NV; i++) begin
      if (V_OP1[i] == a && V_OP2[i] == b && V_SEL[i] == op) begin
        fpu_stub = V_RES[i];
      end
    end
  endfunction

  assign fpu_out = fpu_stub(fpu_op1, fpu_op2, fpu_opsel);

  fpu_issue_queue #(.DEPTH(4)) dut (
    .i_w_clk       (clk),
    .i_w_rst_n     (rst_n),
    .i_w_cmd_valid (cmd_valid),
    .o_w_cmd_ready (cmd_ready),
    .i_w_cmd_op1   (cmd_op1),
    .i_w_cmd_op2   (cmd_op2),
    .i_w_cmd_opsel (cmd_opsel),
    .o_w_fpu_op1   (fpu_op1),
    .o_w_fpu_op2   (fpu_op2),
    .o_w_fpu_opsel (fpu_opsel),
    .i_w_fpu_out   (fpu_out),
    .o_w_res_valid (res_valid),
    .i_w_res_ready (res_ready),
    .o_w_res_data  (res_data),
    .o_w_res_opsel (res_opsel),
    .o_w_count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int i);
    cmd_valid = 1'b1;
    cmd_op1   = V_OP1[i];
    cmd_op2   = V_OP2[i];
    cmd_opsel = V_SEL[i];
  endtask

  task automatic idle();
    cmd_valid = 1'b0;
    cmd_op1   = 32'd0;
    cmd_op2   = 32'd0;
    cmd_opsel = 3'd0;
  endtask

  // With res_ready low, push vectors 0.. until refused. Expect 5 accepted: 4 in the FIFO and 1 in the result slot.
  task automatic fill_until_refused();
    int acc;
    acc = 0;
    res_ready = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (cmd_ready) begin
        drive(acc);
        acc++;
      end else begin
        idle();
        break;
      end
    end
    chk("bp_accepted", 32'(acc), 32'd5);
    chk("bp_count", 32'(count), 32'd4);
    chk("bp_ready_low", 32'(cmd_ready), 32'd0);
    chk("bp_res_valid", 32'(res_valid), 32'd1);
    chk("bp_first_res", res_data, V_RES[0]);
  endtask

  initial begin
    rst_n = 1'b0;
    res_ready = 1'b1;
    idle();
    #12;
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_data", res_data, 32'd0);
    chk("rst_opsel", 32'(res_opsel), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_fpu_op1", fpu_op1, 32'd0);
    chk("rst_fpu_sel", 32'(fpu_opsel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);

    // Single add: the result is valid two edges after the push, for exactly one cycle.
    drive(8);
    @(negedge clk);
    idle();
    chk("add_count1", 32'(count), 32'd1);
    chk("add_fpu_op1", fpu_op1, 32'h3F800000);
    chk("add_fpu_op2", fpu_op2, 32'h40000000);
    chk("add_valid_early", 32'(res_valid), 32'd0);
    @(negedge clk);
    chk("add_valid", 32'(res_valid), 32'd1);
    chk("add_data", res_data, 32'h40400000);
    chk("add_opsel", 32'(res_opsel), 32'd0);
    chk("add_count0", 32'(count), 32'd0);
    chk("add_fpu_empty", fpu_op1, 32'd0);
    @(negedge clk);
    chk("add_valid_drop", 32'(res_valid), 32'd0);
    chk("add_data_hold", res_data, 32'h40400000);

    // Streaming: 8 back-to-back commands produce 8 consecutive results.
    for (int c = 0; c < 10; c++) begin
      if (c >= 2) begin
        chk($sformatf("str_valid%0d", c - 2), 32'(res_valid), 32'd1);
        chk($sformatf("str_data%0d", c - 2), res_data, V_RES[c-2]);
        chk($sformatf("str_sel%0d", c - 2), 32'(res_opsel), 32'(V_SEL[c-2]));
      end
      if (c < 8) drive(c);
      else idle();
      @(negedge clk);
    end
    chk("str_end_valid", 32'(res_valid), 32'd0);
    chk("str_end_count", 32'(count), 32'd0);

    // Backpressure: fill, hold, then drain.
    fill_until_refused();
    @(negedge clk);
    chk("bp_hold_data", res_data, V_RES[0]);
    chk("bp_hold_sel", 32'(res_opsel), 32'(V_SEL[0]));
    chk("bp_hold_valid", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("drain_data%0d", k), res_data, V_RES[k]);
      chk($sformatf("drain_count%0d", k), 32'(count), 32'(4 - k));
      chk($sformatf("drain_ready%0d", k), 32'(cmd_ready), 32'd1);
    end
    @(negedge clk);
    chk("drain_end_valid", 32'(res_valid), 32'd0);

    // Full boundary: a command offered at full waits one edge, then is accepted.
    fill_until_refused();
    drive(5);
    res_ready = 1'b1;
    @(negedge clk);
    chk("full_count3", 32'(count), 32'd3);
    chk("full_ready", 32'(cmd_ready), 32'd1);
    chk("full_res1", res_data, V_RES[1]);
    @(negedge clk);
    idle();
    chk("full_count_pp", 32'(count), 32'd3);
    chk("full_res2", res_data, V_RES[2]);
    for (int k = 3; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("full_res%0d", k), res_data, V_RES[k]);
      chk($sformatf("full_cnt%0d", k), 32'(count), 32'(5 - k));
    end
    @(negedge clk);
    chk("full_end_valid", 32'(res_valid), 32'd0);

    // Simultaneous push and pop at count 2.
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(i);
      @(negedge clk);
    end
    idle();
    chk("pp_count2", 32'(count), 32'd2);
    drive(3);
    res_ready = 1'b1;
    @(negedge clk);
    idle();
    chk("pp_count_same", 32'(count), 32'd2);
    chk("pp_res1", res_data, V_RES[1]);
    @(negedge clk);
    chk("pp_res2", res_data, V_RES[2]);
    chk("pp_cnt1", 32'(count), 32'd1);
    @(negedge clk);
    chk("pp_res3", res_data, V_RES[3]);
    chk("pp_cnt0", 32'(count), 32'd0);
    @(negedge clk);
    chk("pp_end_valid", 32'(res_valid), 32'd0);

    // Reset mid-stream: 3 queued plus a pending result are discarded.
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(i);
      @(negedge clk);
    end
    idle();
    chk("mid_count3", 32'(count), 32'd3);
    chk("mid_pending", 32'(res_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_fpu1", fpu_op1, 32'd0);
    chk("mid_rst_fpu2", fpu_op2, 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("mid_stale%0d", k), 32'(res_valid), 32'd0);
      chk($sformatf("mid_cnt%0d", k), 32'(count), 32'd0);
    end
    drive(8);
    @(negedge clk);
    idle();
    @(negedge clk);
    chk("mid_after_valid", 32'(res_valid), 32'd1);
    chk("mid_after_data", res_data, 32'h40400000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
